// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code: encoder states
// and the symbol function used by both the encoder and the decoder models.
package viterbi_pkg;

    localparam int          K      = 3;
    localparam int          RATE_N = 2;
    localparam logic [2:0]  G0_DEF = 3'b111;
    localparam logic [2:0]  G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TAIL1 = 2'd1,
        TAIL2 = 2'd2
    } enc_state_t;

    // Window is {u, sreg[1], sreg[0]}; MSB of each generator taps the current bit.
    function automatic logic [1:0] conv_sym(input logic       u,
                                            input logic [1:0] sreg,
                                            input logic [2:0] g0,
                                            input logic [2:0] g1);
        logic [2:0] w;
        w = {u, sreg};
        return {^(w & g0), ^(w & g1)};
    endfunction

endpackage

// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder with a single output register and an
// automatic two-bit zero tail so every frame terminates in trellis state 0.
module conv_enc_k3
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0    = G0_DEF,
    parameter logic [2:0] G1    = G1_DEF,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       enc_pair,
    output logic             out_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_syms
);

    enc_state_t       state, state_nxt;
    logic [1:0]       sreg;
    logic [CNT_W-1:0] sym_cnt, cnt_base, cnt_nxt;
    logic             slot_free, load, u_cur, last_nxt, last_acc;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == RUN) && slot_free;
    assign last_acc  = out_valid && out_ready && out_last;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        u_cur     = 1'b0;
        last_nxt  = 1'b0;
        case (state)
            RUN: begin
                if (in_valid && in_ready) begin
                    load  = 1'b1;
                    u_cur = in_bit;
                    if (in_last) state_nxt = TAIL1;
                end
            end
            TAIL1: begin
                if (slot_free) begin
                    load      = 1'b1;
                    state_nxt = TAIL2;
                end
            end
            TAIL2: begin
                if (slot_free) begin
                    load      = 1'b1;
                    last_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // A new frame's first bit can load in the same cycle the previous
    // frame's last symbol drains, so the restart and the increment combine.
    always_comb begin
        cnt_base = last_acc ? '0 : sym_cnt;
        cnt_nxt  = cnt_base;
        if (load && (cnt_base != '1)) cnt_nxt = cnt_base + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            sreg       <= 2'b00;
            out_valid  <= 1'b0;
            enc_pair   <= 2'b00;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_syms <= '0;
            sym_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            sym_cnt    <= cnt_nxt;
            frame_done <= last_acc;
            if (last_acc) frame_syms <= sym_cnt;
            if (load) begin
                enc_pair  <= conv_sym(u_cur, sreg, G0, G1);
                out_valid <= 1'b1;
                out_last  <= last_nxt;
                sreg      <= {u_cur, sreg[1]};
            end else if (slot_free) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/conv_enc_k3.md
Name: conv_enc_k3

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch metric/ACS path and produces the rx_pair symbol stream that the decoder consumes. It accepts one data bit per handshake and emits one 2-bit coded symbol per handshake. At end of frame it appends K-1 = 2 zero tail bits, so the decoder's trellis terminates in state 0.

Parameters:
- G0, 3'b111, generator for enc_pair[1] (MSB applies to current bit)
- G1, 3'b101, generator for enc_pair[0]
- CNT_W, 16, width of the per-frame symbol counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  data bit valid
- in_ready  output  1  encoder accepts in_bit this cycle
- in_bit  input  1  data bit
- in_last  input  1  marks final data bit of frame
- out_valid  output  1  enc_pair valid
- out_ready  input  1  downstream accepts enc_pair
- enc_pair  output  2  coded symbol {c0,c1}; same bit order as decoder rx_pair
- out_last  output  1  marks final (second tail) symbol of frame
- frame_done  output  1  one-cycle pulse when the out_last symbol is accepted
- frame_syms  output  CNT_W  symbols in last completed frame, including tail

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Async assert, sync deassert externally.
- Reset values: state=RUN, sreg=2'b00, out_valid=0, enc_pair=0, out_last=0, frame_done=0, frame_syms=0, internal sym_cnt=0.
- Shift register: sreg[1] holds the previous bit and sreg[0] the bit before it. The current window is w={u,sreg[1],sreg[0]}.
- Coding: c0=^(w&G0) and c1=^(w&G1). enc_pair={c0,c1}.
- Output register: a single register. The slot is free when !out_valid || out_ready.
- in_ready = (state==RUN) && slot_free. It is purely combinational from registered state and out_ready.
- Accept (in_valid && in_ready):
  - load enc_pair from u=in_bit, set out_valid=1, out_last=0
  - shift sreg <= {in_bit,sreg[1]}; sym_cnt++
  - if in_last, go to TAIL1
- TAIL1: when slot free, emit the pair for u=0, shift, sym_cnt++, go to TAIL2. in_ready=0.
- TAIL2: when slot free, emit the pair for u=0 with out_last=1, shift (sreg becomes 00), go to RUN. in_ready=0.
- Slot free with no new symbol loaded: out_valid<=0.
- Throughput: 1 symbol/cycle with out_ready held high. Latency is 1 cycle from accept to out_valid.
- Backpressure: while out_valid && !out_ready, enc_pair, out_last and state hold, and in_ready=0.
- Frame completion: when the out_last symbol is accepted:
  - frame_done pulses for 1 cycle
  - frame_syms <= final count (data+2)
  - sym_cnt <= 0
- sym_cnt saturates at all-ones and does not wrap.
- A frame with only tail symbols is not possible. Every frame has at least 1 data bit, 3 symbols minimum.
- in_last without an accept is ignored.
- Reset mid-frame discards the frame: sreg clears, any pending symbol is dropped, no out_last and no frame_done are produced.
- RUN with sreg≠0 between frames cannot occur, because every frame ends with the tail.

Decomposition:
- Shared package viterbi_pkg holds:
  - K=3, RATE_N=2, G0/G1 defaults shared with the decoder's expected-symbol logic
  - enc_state_t enum {RUN,TAIL1,TAIL2}
  - function conv_sym(u, sreg, g0, g1) returning the 2-bit symbol, reused by decoder model/testbench
- No sub-module. The core is a 3-state FSM, a 2-bit shift register and one output register.

Test Plan:
- Frame bits 1,0,1,1 (last on 4th), out_ready=1 → enc_pair 11,10,00,01,01,11 on consecutive cycles; out_last only on the 6th; frame_done pulse; frame_syms=6.
- Single-bit frame 1 (last) → 11,10,11; in_ready=0 for the two tail cycles; frame_syms=3.
- Same 4-bit frame with out_ready toggling 1,0,0,1,... → identical symbol sequence; enc_pair held stable while stalled; in_ready=0 during stalls; no bit lost or duplicated.
- Back-to-back frames 1,1(last) then 0,1(last) → 11,01,01,11 then 00,11,10,11; second frame starts from sreg=00.
- Assert rst_n low mid-frame after 2 symbols → out_valid=0 immediately (async); after release, frame 1(last) yields 11,10,11 with frame_syms=3.
- Random 1000-bit frames fed through the decoder with zero channel errors → decoded bits equal the input bits; every frame ends in trellis state 0.
